// File: rtl/ac_compressor_sequencer.sv
// AC compressor / fan sequencer: fan pre-run, minimum on-time,
// fan post-run and anti-short-cycle lockout, with immediate abort.
module ac_compressor_sequencer #(
    parameter int CNT_W    = 8,
    parameter int FAN_PRE  = 2,
    parameter int MIN_ON   = 4,
    parameter int FAN_POST = 2,
    parameter int MIN_OFF  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       cool_req,
    input  logic       window,
    input  logic       heating_on,
    output logic       fan_on,
    output logic       compressor_on,
    output logic       lockout,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FAN_PRE  = 3'd1,
        S_COOLING  = 3'd2,
        S_FAN_POST = 3'd3,
        S_LOCKOUT  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LD_PRE  = CNT_W'(FAN_PRE);
    localparam logic [CNT_W-1:0] LD_ON   = CNT_W'(MIN_ON);
    localparam logic [CNT_W-1:0] LD_POST = CNT_W'(FAN_POST);
    localparam logic [CNT_W-1:0] LD_OFF  = CNT_W'(MIN_OFF);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fan_q, fan_d;
    logic             comp_q, comp_d;
    logic             lock_q, lock_d;

    logic             abort;
    logic             cnt_zero;
    logic [CNT_W-1:0] cnt_dec;

    assign abort    = window | heating_on;
    assign cnt_zero = (cnt_q == '0);
    // Counter only moves on a tick and saturates at zero.
    assign cnt_dec  = (tick && !cnt_zero) ? cnt_q - CNT_W'(1) : cnt_q;

    // Next-state, counter load/decrement and output decode of the next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (cool_req && !abort) begin
                    state_d = S_FAN_PRE;
                    cnt_d   = LD_PRE;
                end
            end
            S_FAN_PRE: begin
                if (abort || !cool_req) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_zero) begin
                    state_d = S_COOLING;
                    cnt_d   = LD_ON;
                end else begin
                    cnt_d   = cnt_dec;
                end
            end
            S_COOLING: begin
                if (abort || (!cool_req && cnt_zero)) begin
                    state_d = S_FAN_POST;
                    cnt_d   = LD_POST;
                end else begin
                    cnt_d   = cnt_dec;
                end
            end
            S_FAN_POST: begin
                if (cnt_zero) begin
                    state_d = S_LOCKOUT;
                    cnt_d   = LD_OFF;
                end else begin
                    cnt_d   = cnt_dec;
                end
            end
            S_LOCKOUT: begin
                if (cnt_zero) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_dec;
                end
            end
            default: begin
                state_d = S_LOCKOUT;
                cnt_d   = LD_OFF;
            end
        endcase

        fan_d  = (state_d == S_FAN_PRE) || (state_d == S_COOLING) ||
                 (state_d == S_FAN_POST);
        comp_d = (state_d == S_COOLING);
        lock_d = (state_d == S_LOCKOUT);
    end

    // State, counter and registered outputs; reset lands in lockout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_LOCKOUT;
            cnt_q   <= LD_OFF;
            fan_q   <= 1'b0;
            comp_q  <= 1'b0;
            lock_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fan_q   <= fan_d;
            comp_q  <= comp_d;
            lock_q  <= lock_d;
        end
    end

    assign fan_on        = fan_q;
    assign compressor_on = comp_q;
    assign lockout       = lock_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_ac_compressor_sequencer.sv
// Scoreboard bench for ac_compressor_sequencer: directed steps push the
// hand-derived expected state; a negedge monitor pops and compares.
module tb_ac_compressor_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b1;
    logic       cool_req = 1'b0;
    logic       window = 1'b0;
    logic       heating_on = 1'b0;
    logic       fan_on;
    logic       compressor_on;
    logic       lockout;
    logic [2:0] state_o;

    int checks = 0;
    int failures = 0;

    logic [2:0] exp_q[$];

    localparam logic [2:0] I = 3'd0;
    localparam logic [2:0] P = 3'd1;
    localparam logic [2:0] C = 3'd2;
    localparam logic [2:0] F = 3'd3;
    localparam logic [2:0] L = 3'd4;

    ac_compressor_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .cool_req     (cool_req),
        .window       (window),
        .heating_on   (heating_on),
        .fan_on       (fan_on),
        .compressor_on(compressor_on),
        .lockout      (lockout),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, then queue the state expected after the edge.
    task automatic step(input logic r, input logic cr, input logic w,
                        input logic h, input logic tk, input logic [2:0] es);
        @(negedge clk);
        rst        = r;
        cool_req   = cr;
        window     = w;
        heating_on = h;
        tick       = tk;
        @(posedge clk);
        exp_q.push_back(es);
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: compare every output against the expected state's decode.
    always @(negedge clk) begin
        logic [2:0] e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("state_o", int'(state_o), int'(e));
            chk("fan_on", int'(fan_on), int'(e == P || e == C || e == F));
            chk("compressor_on", int'(compressor_on), int'(e == C));
            chk("lockout", int'(lockout), int'(e == L));
        end
    end

    initial begin
        // 1: reset, then cool_req held through lockout and pre-run
        step(1, 1, 0, 0, 1, L);
        step(0, 1, 0, 0, 1, L);
        step(0, 1, 0, 0, 1, L);
        step(0, 1, 0, 0, 1, L);
        step(0, 1, 0, 0, 1, I);
        step(0, 1, 0, 0, 1, P);
        step(0, 1, 0, 0, 1, P);
        step(0, 1, 0, 0, 1, P);
        step(0, 1, 0, 0, 1, C);
        // 2: request dropped on first cooling cycle, min on-time honoured
        step(0, 0, 0, 0, 1, C);
        step(0, 0, 0, 0, 1, C);
        step(0, 0, 0, 0, 1, C);
        step(0, 0, 0, 0, 1, C);
        step(0, 0, 0, 0, 1, F);
        step(0, 0, 0, 0, 1, F);
        step(0, 0, 0, 0, 1, F);
        step(0, 0, 0, 0, 1, L);
        step(0, 0, 0, 0, 1, L);
        step(0, 0, 0, 0, 1, L);
        step(0, 0, 0, 0, 1, L);
        step(0, 0, 0, 0, 1, I);
        // abort in idle blocks start
        step(0, 1, 1, 0, 1, I);
        step(0, 1, 0, 1, 1, I);
        // 3: window abort on second cooling cycle
        step(0, 1, 0, 0, 1, P);
        step(0, 1, 0, 0, 1, P);
        step(0, 1, 0, 0, 1, P);
        step(0, 1, 0, 0, 1, C);
        step(0, 1, 0, 0, 1, C);
        step(0, 1, 1, 0, 1, F);
        step(0, 1, 1, 0, 1, F);
        step(0, 1, 0, 1, 1, F);
        step(0, 1, 0, 0, 1, L);
        step(0, 1, 0, 0, 1, L);
        step(0, 1, 0, 0, 1, L);
        step(0, 1, 0, 0, 1, L);
        step(0, 1, 0, 0, 1, I);
        step(0, 1, 0, 0, 1, P);
        step(0, 1, 0, 0, 1, P);
        step(0, 1, 0, 0, 1, P);
        step(0, 1, 0, 0, 1, C);
        // heating abort on first cooling cycle
        step(0, 1, 0, 1, 1, F);
        step(0, 0, 0, 0, 1, F);
        step(0, 0, 0, 0, 1, F);
        step(0, 0, 0, 0, 1, L);
        step(0, 0, 0, 0, 1, L);
        step(0, 0, 0, 0, 1, L);
        step(0, 0, 0, 0, 1, L);
        step(0, 0, 0, 0, 1, I);
        step(0, 0, 0, 0, 1, I);
        // 4: pre-run cancel and immediate restart
        step(0, 1, 0, 0, 1, P);
        step(0, 1, 0, 0, 1, P);
        step(0, 0, 0, 0, 1, I);
        step(0, 1, 0, 0, 1, P);
        step(0, 1, 0, 0, 1, P);
        step(0, 1, 0, 0, 1, P);
        // abort coincident with pre-run expiry wins
        step(0, 1, 0, 1, 1, I);
        // 5: tick every 4 cycles; pre-run holds 9 cycles
        step(0, 1, 0, 0, 0, P);
        step(0, 1, 0, 0, 0, P);
        step(0, 1, 0, 0, 0, P);
        step(0, 1, 0, 0, 0, P);
        step(0, 1, 0, 0, 1, P);
        step(0, 1, 0, 0, 0, P);
        step(0, 1, 0, 0, 0, P);
        step(0, 1, 0, 0, 0, P);
        step(0, 1, 0, 0, 1, P);
        step(0, 1, 0, 0, 0, C);
        // no ticks: min on-time cannot expire
        step(0, 0, 0, 0, 0, C);
        step(0, 0, 0, 0, 0, C);
        step(0, 0, 0, 0, 0, C);
        // 6: reset mid-cooling, lockout holds without ticks
        step(1, 1, 0, 0, 1, L);
        step(0, 1, 0, 0, 0, L);
        step(0, 1, 0, 0, 0, L);
        step(0, 1, 0, 0, 1, L);
        step(0, 1, 0, 0, 1, L);
        step(0, 1, 0, 0, 1, L);
        step(0, 1, 0, 0, 1, I);
        step(0, 1, 0, 0, 1, P);

        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
